// File: rtl/flit_sink_monitor_pkg.sv
// flit_sink_monitor_pkg: error bit positions, LFSR taps and sizing helpers for the flit sink.
package flit_sink_monitor_pkg;
  localparam int err_overflow = 0;
  localparam int err_head_open = 1;
  localparam int err_no_head = 2;
  localparam logic [9:0] lfsr_taps = 10'h240;
  function automatic logic [9:0] lfsr_next(input logic [9:0] s);
    return {s[8:0], ^(s & lfsr_taps)};
  endfunction
  function automatic int clogb(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sink_vc_fifo.sv
// sink_vc_fifo: per-VC flit buffer; a push into a full FIFO is legal when it is popped the same cycle.
module sink_vc_fifo #(
  parameter int depth = 4,
  parameter int width = 65
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic [width-1:0] rd_data
);
  localparam int aw = $clog2(depth);
  logic [width-1:0] mem [depth];
  logic [aw:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[aw-1:0] == rp[aw-1:0]) && (wp[aw] != rp[aw]);
  assign rd_data = mem[rp[aw-1:0]];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wp[aw-1:0]] <= wr_data;
endmodule

// File: rtl/flit_sink_monitor.sv
// flit_sink_monitor: per-VC buffered flit sink with LFSR-throttled round-robin drain,
// credit return, head/tail protocol checking and saturating statistics.
module flit_sink_monitor
  import flit_sink_monitor_pkg::*;
#(
  parameter int num_vcs = 4,
  parameter int buffer_depth = 4,
  parameter int flit_data_width = 64,
  parameter int consume_rate = 1024,
  parameter logic [9:0] lfsr_seed = 10'h1,
  parameter int count_width = 32,
  localparam int vw = clogb(num_vcs)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flit_valid_in,
  input  logic [vw-1:0]              flit_vc_in,
  input  logic                       flit_head_in,
  input  logic                       flit_tail_in,
  input  logic [flit_data_width-1:0] flit_data_in,
  input  logic                       clear_stats_in,
  output logic                       pop_valid_out,
  output logic [vw-1:0]              pop_vc_out,
  output logic                       pop_tail_out,
  output logic [flit_data_width-1:0] pop_data_out,
  output logic                       credit_valid_out,
  output logic [vw-1:0]              credit_vc_out,
  output logic [num_vcs-1:0]         open_pkt_out,
  output logic [count_width-1:0]     pkt_count_out,
  output logic [count_width-1:0]     flit_count_out,
  output logic [2:0]                 error_out
);
  logic [num_vcs-1:0] push, pop, full, empty;
  logic [flit_data_width:0] rd_data [num_vcs];
  logic [vw-1:0] ptr, gnt_vc, cand;
  logic [9:0] lfsr;
  logic consume, gnt, vc_ok, accepted, open_cur, drop;
  logic [2:0] err_set;
  assign consume = {1'b0, lfsr} < 11'(consume_rate);
  // Scan from the pointer backwards so the VC closest to the pointer is chosen last and wins.
  always_comb begin
    gnt_vc = ptr;
    gnt = 1'b0;
    cand = '0;
    for (int i = num_vcs - 1; i >= 0; i--) begin
      cand = vw'((int'(ptr) + i) % num_vcs);
      if (!empty[cand]) begin
        gnt = consume;
        gnt_vc = cand;
      end
    end
  end
  assign pop = {{(num_vcs-1){1'b0}}, gnt} << gnt_vc;
  assign vc_ok = int'(flit_vc_in) < num_vcs;
  assign accepted = flit_valid_in & vc_ok & (!full[flit_vc_in] | pop[flit_vc_in]);
  assign push = {{(num_vcs-1){1'b0}}, accepted} << flit_vc_in;
  assign drop = flit_valid_in & !accepted;
  assign open_cur = open_pkt_out[flit_vc_in];
  always_comb begin
    err_set = '0;
    err_set[err_overflow] = drop;
    err_set[err_head_open] = accepted & flit_head_in & open_cur;
    err_set[err_no_head] = accepted & !flit_head_in & !open_cur;
  end
  for (genvar v = 0; v < num_vcs; v++) begin : g_vc
    sink_vc_fifo #(.depth(buffer_depth), .width(flit_data_width + 1)) u_fifo (
      .clk(clk),
      .reset(reset),
      .push(push[v]),
      .pop(pop[v]),
      .wr_data({flit_tail_in, flit_data_in}),
      .full(full[v]),
      .empty(empty[v]),
      .rd_data(rd_data[v])
    );
  end
  assign credit_valid_out = pop_valid_out;
  assign credit_vc_out = pop_vc_out;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ptr <= '0;
      lfsr <= (lfsr_seed == 10'h0) ? 10'h1 : lfsr_seed;
      pop_valid_out <= 1'b0;
      pop_vc_out <= '0;
      pop_tail_out <= 1'b0;
      pop_data_out <= '0;
      open_pkt_out <= '0;
      pkt_count_out <= '0;
      flit_count_out <= '0;
      error_out <= '0;
    end else begin
      lfsr <= lfsr_next(lfsr);
      if (gnt) ptr <= vw'((int'(gnt_vc) + 1) % num_vcs);
      pop_valid_out <= gnt;
      pop_vc_out <= gnt ? gnt_vc : '0;
      {pop_tail_out, pop_data_out} <= gnt ? rd_data[gnt_vc] : '0;
      if (accepted) open_pkt_out[flit_vc_in] <= flit_tail_in ? 1'b0 : (flit_head_in | open_cur);
      if (clear_stats_in) begin
        flit_count_out <= '0;
        pkt_count_out <= '0;
        error_out <= '0;
      end else begin
        flit_count_out <= flit_count_out + count_width'(pop_valid_out & ~&flit_count_out);
        pkt_count_out <= pkt_count_out + count_width'(pop_valid_out & pop_tail_out & ~&pkt_count_out);
        error_out <= error_out | err_set;
      end
    end
endmodule
